control_sequencer: RTL and testbench

//  Microcoded control unit of the 8-bit bus CPU. It drives the bus-control strobes that the

---
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_control_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - opcode/flag inputs and bus-control strobes of the CPU control unit
interface control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                flag_c;
    logic                flag_z;

    logic                co_n;
    logic                ce;
    logic                j_n;
    logic                mi_n;
    logic                ro_n;
    logic                ri_n;
    logic                ii_n;
    logic                io_n;
    logic                ai_n;
    logic                ao_n;
    logic                eo_n;
    logic                bi_n;
    logic                oi_n;
    logic                su;
    logic                fi;
    logic                hlt;
    logic [2:0]          step;

    modport master (
        input  opcode, flag_c, flag_z,
        output co_n, ce, j_n, mi_n, ro_n, ri_n, ii_n, io_n,
               ai_n, ao_n, eo_n, bi_n, oi_n, su, fi, hlt, step
    );

    modport slave (
        output opcode, flag_c, flag_z,
        input  co_n, ce, j_n, mi_n, ro_n, ri_n, ii_n, io_n,
               ai_n, ao_n, eo_n, bi_n, oi_n, su, fi, hlt, step
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded T-state sequencer driving the 8-bit CPU bus-control strobes
module control_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int NUM_T     = 5,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                clr_n,
    control_sequencer_if.master bus
);
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T_FINAL = 3'(NUM_T - 1);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0111);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b1000);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

    logic [OPCODE_W-1:0] op;
    logic [2:0]          step_q;
    logic                halted_q;
    logic [2:0]          last_step;
    logic [2:0]          end_step;
    logic                halt_now;

    logic co, cnt, jmp, mi, ro, ri, ii, io, ai, ao, eo, bi, oi, sub, fl, hl;

    assign op = bus.opcode;

    always_comb begin
        last_step = T1;
        case (op)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
            OP_LDA, OP_STA:                               last_step = T3;
            OP_ADD, OP_SUB:                               last_step = T4;
            default:                                      last_step = T1;
        endcase
    end

    assign end_step = (EARLY_END != 0) ? last_step : T_FINAL;
    assign halt_now = !halted_q && (step_q == T2) && (op == OP_HLT);

    // Halting pins the step counter at T2 so the debug port shows where the machine stopped.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (halted_q || halt_now) begin
            step_q   <= T2;
            halted_q <= 1'b1;
        end else if ((step_q == end_step) || (step_q >= T_FINAL)) begin
            step_q   <= T0;
        end else begin
            step_q   <= step_q + 3'd1;
        end
    end

    // Active-high control word; clr_n gates it directly so strobes die without a clock edge.
    always_comb begin
        co = 1'b0; cnt = 1'b0; jmp = 1'b0; mi = 1'b0; ro = 1'b0; ri = 1'b0;
        ii = 1'b0; io = 1'b0; ai = 1'b0; ao = 1'b0; eo = 1'b0; bi = 1'b0;
        oi = 1'b0; sub = 1'b0; fl = 1'b0; hl = 1'b0;
        if (clr_n && halted_q) begin
            hl = 1'b1;
        end else if (clr_n) begin
            case (step_q)
                T0: begin
                    co = 1'b1;
                    mi = 1'b1;
                end
                T1: begin
                    ro  = 1'b1;
                    ii  = 1'b1;
                    cnt = 1'b1;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1;
                            mi = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_JMP: begin
                            io  = 1'b1;
                            jmp = 1'b1;
                        end
                        OP_JC: begin
                            io  = 1'b1;
                            jmp = bus.flag_c;
                        end
                        OP_JZ: begin
                            io  = 1'b1;
                            jmp = bus.flag_z;
                        end
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        OP_HLT: hl = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        eo  = 1'b1;
                        ai  = 1'b1;
                        fl  = 1'b1;
                        sub = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.co_n = ~co;
    assign bus.ce   = cnt;
    assign bus.j_n  = ~jmp;
    assign bus.mi_n = ~mi;
    assign bus.ro_n = ~ro;
    assign bus.ri_n = ~ri;
    assign bus.ii_n = ~ii;
    assign bus.io_n = ~io;
    assign bus.ai_n = ~ai;
    assign bus.ao_n = ~ao;
    assign bus.eo_n = ~eo;
    assign bus.bi_n = ~bi;
    assign bus.oi_n = ~oi;
    assign bus.su   = sub;
    assign bus.fi   = fl;
    assign bus.hlt  = hl;
    assign bus.step = step_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer (EARLY_END=1 and EARLY_END=0 builds)
module tb_control_sequencer;
    localparam logic [15:0] IDLE  = 16'hBFF8;
    localparam logic [15:0] M_CO  = 16'h8000;
    localparam logic [15:0] M_CE  = 16'h4000;
    localparam logic [15:0] M_J   = 16'h2000;
    localparam logic [15:0] M_MI  = 16'h1000;
    localparam logic [15:0] M_RO  = 16'h0800;
    localparam logic [15:0] M_RI  = 16'h0400;
    localparam logic [15:0] M_II  = 16'h0200;
    localparam logic [15:0] M_IO  = 16'h0100;
    localparam logic [15:0] M_AI  = 16'h0080;
    localparam logic [15:0] M_AO  = 16'h0040;
    localparam logic [15:0] M_EO  = 16'h0020;
    localparam logic [15:0] M_BI  = 16'h0010;
    localparam logic [15:0] M_OI  = 16'h0008;
    localparam logic [15:0] M_SU  = 16'h0004;
    localparam logic [15:0] M_FI  = 16'h0002;
    localparam logic [15:0] M_HLT = 16'h0001;

    typedef struct {
        int          sel;
        logic [15:0] w;
        logic [2:0]  st;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic clr_n0 = 1'b0;
    logic clr_n1 = 1'b0;

    control_sequencer_if bus0();
    control_sequencer_if bus1();

    control_sequencer #(.OPCODE_W(4), .NUM_T(5), .EARLY_END(1)) dut0 (
        .clk(clk), .clr_n(clr_n0), .bus(bus0.master)
    );
    control_sequencer #(.OPCODE_W(4), .NUM_T(5), .EARLY_END(0)) dut1 (
        .clk(clk), .clr_n(clr_n1), .bus(bus1.master)
    );

    always #5 clk = ~clk;

    logic [15:0] w0, w1;
    assign w0 = {bus0.co_n, bus0.ce, bus0.j_n, bus0.mi_n, bus0.ro_n, bus0.ri_n, bus0.ii_n, bus0.io_n,
                 bus0.ai_n, bus0.ao_n, bus0.eo_n, bus0.bi_n, bus0.oi_n, bus0.su, bus0.fi, bus0.hlt};
    assign w1 = {bus1.co_n, bus1.ce, bus1.j_n, bus1.mi_n, bus1.ro_n, bus1.ri_n, bus1.ii_n, bus1.io_n,
                 bus1.ai_n, bus1.ao_n, bus1.eo_n, bus1.bi_n, bus1.oi_n, bus1.su, bus1.fi, bus1.hlt};

    task automatic cyc(input int sel, input logic [3:0] op, input logic fc, input logic fz,
                       input logic rstn, input logic [15:0] act, input logic [2:0] st, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 0) begin
            bus0.opcode = op; bus0.flag_c = fc; bus0.flag_z = fz; clr_n0 = rstn;
        end else begin
            bus1.opcode = op; bus1.flag_c = fc; bus1.flag_z = fz; clr_n1 = rstn;
        end
        e.sel = sel; e.w = IDLE ^ act; e.st = st; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic instr(input int sel, input logic [3:0] op, input logic fc, input logic fz,
                         input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4, input int n);
        logic [15:0] acts [5];
        acts[0] = M_CO | M_MI;
        acts[1] = M_RO | M_II | M_CE;
        acts[2] = t2;
        acts[3] = t3;
        acts[4] = t4;
        for (int k = 0; k < n; k++)
            cyc(sel, op, fc, fz, 1'b1, acts[k], 3'(k), $sformatf("d%0d_op%h_T%0d", sel, op, k));
    endtask

    initial begin : monitor
        exp_t        r;
        logic [15:0] aw;
        logic [2:0]  ast;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r   = sb.pop_front();
                aw  = (r.sel == 0) ? w0 : w1;
                ast = (r.sel == 0) ? bus0.step : bus1.step;
                checks++;
                if (aw !== r.w) begin
                    errors++;
                    $display("FAIL %s ctrl: got %h expected %h", r.nm, aw, r.w);
                end
                checks++;
                if (ast !== r.st) begin
                    errors++;
                    $display("FAIL %s step: got %0d expected %0d", r.nm, ast, r.st);
                end
            end
        end
    end

    initial begin : stimulus
        bus0.opcode = 4'h0; bus0.flag_c = 1'b0; bus0.flag_z = 1'b0;
        bus1.opcode = 4'h0; bus1.flag_c = 1'b0; bus1.flag_z = 1'b0;

        cyc(0, 4'h0, 0, 0, 1'b0, 16'h0, 3'd0, "d0_reset");
        instr(0, 4'h0, 0, 0, 0, 0, 0, 2);
        instr(0, 4'h2, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI, 5);
        instr(0, 4'h3, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI | M_SU, 5);
        instr(0, 4'h1, 0, 0, M_IO | M_MI, M_RO | M_AI, 0, 4);
        instr(0, 4'h4, 0, 0, M_IO | M_MI, M_AO | M_RI, 0, 4);
        instr(0, 4'h5, 0, 0, M_IO | M_AI, 0, 0, 3);
        instr(0, 4'h6, 0, 0, M_IO | M_J, 0, 0, 3);
        instr(0, 4'h7, 0, 1, M_IO, 0, 0, 3);
        instr(0, 4'h7, 1, 0, M_IO | M_J, 0, 0, 3);
        instr(0, 4'h8, 1, 0, M_IO, 0, 0, 3);
        instr(0, 4'h8, 0, 1, M_IO | M_J, 0, 0, 3);
        instr(0, 4'hE, 0, 0, M_AO | M_OI, 0, 0, 3);
        instr(0, 4'hA, 0, 0, 0, 0, 0, 2);

        instr(0, 4'h2, 0, 0, M_IO | M_MI, 0, 0, 3);
        cyc(0, 4'h2, 0, 0, 1'b0, 16'h0, 3'd0, "d0_reset_in_T3");
        cyc(0, 4'h2, 0, 0, 1'b0, 16'h0, 3'd0, "d0_reset_held");
        instr(0, 4'h0, 0, 0, 0, 0, 0, 2);

        instr(0, 4'hF, 0, 0, M_HLT, 0, 0, 3);
        for (int i = 0; i < 20; i++)
            cyc(0, 4'(i), 1'(i), 1'(i >> 1), 1'b1, M_HLT, 3'd2, $sformatf("d0_halted_%0d", i));
        cyc(0, 4'h0, 0, 0, 1'b0, 16'h0, 3'd0, "d0_halt_clear");
        instr(0, 4'h0, 0, 0, 0, 0, 0, 2);

        cyc(1, 4'h5, 0, 0, 1'b0, 16'h0, 3'd0, "d1_reset");
        instr(1, 4'h5, 0, 0, M_IO | M_AI, 0, 0, 5);
        instr(1, 4'hA, 0, 0, 0, 0, 0, 5);
        instr(1, 4'h2, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI, 5);
        instr(1, 4'h0, 0, 0, 0, 0, 0, 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
